// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared fetch-stage defaults and queue-entry layout
package fe_pkg;

    localparam int          FE_DBITS    = 32;
    localparam int          FE_INSTBITS = 32;
    localparam int          FE_INSTSIZE = 4;
    localparam logic [31:0] FE_STARTPC  = 32'h100;

    // Field order matches the packed word stored in the fetch queue.
    typedef struct packed {
        logic [FE_INSTBITS-1:0] inst;
        logic [FE_DBITS-1:0]    pc;
        logic [FE_DBITS-1:0]    pcplus;
        logic [FE_DBITS-1:0]    inst_count;
    } fe_entry_t;

endpackage

// File: rtl/fe_fifo.sv
// rtl/fe_fifo.sv - synchronous FIFO with flush, head read combinationally from storage
module fe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + AW'(1);
            if (do_pop) rptr_d = rptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Push at full is legal only alongside a pop: the slot being written is the one leaving.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fe_fetch_queue.sv
// rtl/fe_fetch_queue.sv - credit-limited instruction fetch with decoupling queue and redirect flush
module fe_fetch_queue
    import fe_pkg::*;
#(
    parameter int               DBITS    = FE_DBITS,
    parameter int               INSTBITS = FE_INSTBITS,
    parameter int               QDEPTH   = 4,
    parameter logic [DBITS-1:0] STARTPC  = DBITS'(FE_STARTPC),
    parameter int               INSTSIZE = FE_INSTSIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [DBITS-1:0]        imem_addr,
    input  logic [INSTBITS-1:0]     imem_rdata,
    input  logic                    redirect_valid,
    input  logic [DBITS-1:0]        redirect_pc,
    input  logic                    de_ready,
    output logic                    out_valid,
    output logic [INSTBITS-1:0]     out_inst,
    output logic [DBITS-1:0]        out_pc,
    output logic [DBITS-1:0]        out_pcplus,
    output logic [DBITS-1:0]        out_inst_count,
    output logic [$clog2(QDEPTH):0] q_count
);
    localparam int               CW  = $clog2(QDEPTH) + 1;
    localparam int               EW  = INSTBITS + 3 * DBITS;
    localparam int               AL  = $clog2(INSTSIZE);
    localparam logic [DBITS-1:0] INC = DBITS'(INSTSIZE);

    logic [DBITS-1:0]    pc_q, pc_d, if_pc_q, if_pc_d, cnt_q, cnt_d, last_q, last_d;
    logic                if_valid_q, if_valid_d, delivered_q, delivered_d;
    logic                fetch, deq, enq;
    logic [CW:0]         occ;
    logic [EW-1:0]       push_data, head_data;
    logic [INSTBITS-1:0] h_inst;
    logic [DBITS-1:0]    h_pc, h_pcplus, h_cnt, redirect_base;

    assign redirect_base = (redirect_pc >> AL) << AL;
    assign {h_inst, h_pc, h_pcplus, h_cnt} = head_data;

    always_comb begin
        deq       = out_valid && de_ready;
        enq       = if_valid_q && !redirect_valid;
        // Credits: held entries plus the response still in flight, less what leaves this cycle.
        occ       = (CW+1)'(q_count) + (CW+1)'(if_valid_q) - (CW+1)'(deq);
        fetch     = !redirect_valid && (occ < (CW+1)'(QDEPTH));
        push_data = {imem_rdata, if_pc_q, if_pc_q + INC, cnt_q};

        pc_d        = pc_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        delivered_d = delivered_q;
        if_valid_d  = fetch;
        if_pc_d     = pc_q;

        if (deq) begin
            last_d      = h_cnt;
            delivered_d = 1'b1;
        end
        if (redirect_valid) begin
            pc_d  = redirect_base;
            cnt_d = (deq || delivered_q) ? last_d + DBITS'(1) : DBITS'(1);
        end else begin
            if (fetch) pc_d = pc_q + INC;
            if (enq) cnt_d = cnt_q + DBITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= STARTPC;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            cnt_q       <= DBITS'(1);
            last_q      <= '0;
            delivered_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            delivered_q <= delivered_d;
        end
    end

    fe_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .reset_ni    (reset),
        .flush_i     (redirect_valid),
        .push_i      (enq),
        .push_data_i (push_data),
        .pop_i       (deq),
        .head_o      (head_data),
        .count_o     (q_count)
    );

    assign imem_req       = fetch && reset;
    assign imem_addr      = pc_q;
    assign out_valid      = (q_count != '0);
    assign out_inst       = out_valid ? h_inst   : '0;
    assign out_pc         = out_valid ? h_pc     : '0;
    assign out_pcplus     = out_valid ? h_pcplus : '0;
    assign out_inst_count = out_valid ? h_cnt    : '0;

endmodule

// File: tb/tb_fe_fetch_queue.sv
// tb/tb_fe_fetch_queue.sv - randomized bench with queue-based reference model for fe_fetch_queue
module tb_fe_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, imem_req, redirect_valid, de_ready, out_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_inst, out_pc, out_pcplus, out_inst_count;
    logic [2:0]  q_count;

    logic        s_imem_req, s_redirect_valid, s_de_ready, s_out_valid;
    logic [7:0]  s_imem_addr, s_redirect_pc, s_out_pc, s_out_pcplus, s_out_cnt;
    logic [31:0] s_imem_rdata, s_out_inst;
    logic [2:0]  s_q_count;

    fe_fetch_queue dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .de_ready(de_ready), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_pcplus(out_pcplus), .out_inst_count(out_inst_count), .q_count(q_count)
    );

    fe_fetch_queue #(.DBITS(8), .STARTPC(8'hFC)) dut_s (
        .clk(clk), .reset(reset), .imem_req(s_imem_req), .imem_addr(s_imem_addr),
        .imem_rdata(s_imem_rdata), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .de_ready(s_de_ready), .out_valid(s_out_valid), .out_inst(s_out_inst), .out_pc(s_out_pc),
        .out_pcplus(s_out_pcplus), .out_inst_count(s_out_cnt), .q_count(s_q_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f(input logic [31:0] a);
        f = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
    } ent_t;

    ent_t        mq[$];
    ent_t        e;
    logic [31:0] m_pc, m_cnt, m_last, m_ipc, last_addr;
    logic [7:0]  s_last_addr;
    bit          m_any, m_infl, m_deq, m_req;
    int          occ;

    // Reference: instructions wait in a queue; a request becomes an entry one cycle later.
    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            m_pc = 32'h100; m_cnt = 1; m_last = 0; m_any = 0; m_infl = 0; m_ipc = 0;
        end else begin
            occ = mq.size();
            chk("out_valid", 32'(out_valid), 32'(occ > 0));
            chk("q_count", 32'(q_count), 32'(occ));
            if (occ > 0) begin
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_pcplus", out_pcplus, mq[0].pc + 32'd4);
                chk("out_inst", out_inst, f(mq[0].pc));
                chk("out_inst_count", out_inst_count, mq[0].cnt);
            end
            m_deq = (occ > 0) && de_ready;
            m_req = !redirect_valid && ((occ + (m_infl ? 1 : 0) - (m_deq ? 1 : 0)) < 4);
            chk("imem_req", 32'(imem_req), 32'(m_req));
            if (m_req) chk("imem_addr", imem_addr, m_pc);

            if (m_deq) begin
                m_last = mq[0].cnt;
                m_any  = 1;
                void'(mq.pop_front());
            end
            if (redirect_valid) begin
                mq.delete();
                m_cnt  = m_any ? m_last + 1 : 32'd1;
                m_infl = 0;
                m_pc   = redirect_pc & ~32'd3;
            end else begin
                if (m_infl) begin
                    e.pc = m_ipc; e.cnt = m_cnt;
                    mq.push_back(e);
                    m_cnt = m_cnt + 1;
                end
                m_infl = m_req;
                m_ipc  = m_pc;
                if (m_req) m_pc = m_pc + 32'd4;
            end
        end
        last_addr   = imem_addr;
        s_last_addr = s_imem_addr;
    end

    task automatic step(input bit rv, input logic [31:0] rpc, input bit dr);
        @(posedge clk);
        #1;
        imem_rdata     = f(last_addr);
        s_imem_rdata   = f({24'h0, s_last_addr});
        redirect_valid = rv;
        redirect_pc    = rpc;
        de_ready       = dr;
        #1;
    endtask

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; de_ready = 1'b1;
        imem_rdata = '0; s_imem_rdata = '0;
        s_redirect_valid = 1'b0; s_redirect_pc = '0; s_de_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        reset = 1'b1;
        #1;

        chk("c0_addr", imem_addr, 32'h100);
        chk("c0_req", 32'(imem_req), 1);
        chk("s_c0_addr", 32'(s_imem_addr), 32'hFC);
        step(0, 0, 1);
        chk("c1_addr", imem_addr, 32'h104);
        chk("s_c1_addr", 32'(s_imem_addr), 32'h00);
        step(0, 0, 1);
        chk("c2_addr", imem_addr, 32'h108);
        chk("c2_out_valid", 32'(out_valid), 1);
        chk("c2_out_pc", out_pc, 32'h100);
        chk("c2_out_pcplus", out_pcplus, 32'h104);
        chk("c2_inst_count", out_inst_count, 1);
        chk("s_c2_out_pc", 32'(s_out_pc), 32'hFC);
        chk("s_c2_out_pcplus", 32'(s_out_pcplus), 32'h00);
        chk("s_c2_out_inst", s_out_inst, f(32'hFC));
        step(0, 0, 1);
        chk("s_c3_out_pc", 32'(s_out_pc), 32'h00);
        repeat (5) step(0, 0, 1);

        repeat (10) step(0, 0, 0);
        chk("stall_q_count", 32'(q_count), 4);
        chk("stall_req", 32'(imem_req), 0);
        repeat (12) step(0, 0, 1);

        step(1, 32'h1000, 0);
        for (int i = 0; i < 20 && q_count != 3; i++) step(0, 0, 0);
        chk("wait_q3", 32'(q_count), 3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step(0, 0, 1);
        chk("redir_q_count", 32'(q_count), 0);
        chk("redir_addr", imem_addr, 32'h200);
        chk("redir_req", 32'(imem_req), 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("redir_out_pc", out_pc, 32'h200);

        for (int i = 0; i < 20 && !out_valid; i++) step(0, 0, 1);
        chk("wait_head", 32'(out_valid), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        de_ready       = 1'b1;
        step(1, 32'h400, 1);
        step(0, 0, 1);
        chk("b2b_addr", imem_addr, 32'h400);
        chk("b2b_req", 32'(imem_req), 1);
        chk("b2b_q_count", 32'(q_count), 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("b2b_out_pc", out_pc, 32'h400);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);

        repeat (8) step(0, 0, 0);
        chk("pre_rst_q_count", 32'(q_count), 4);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_q_count", 32'(q_count), 0);
        chk("mid_rst_req", 32'(imem_req), 0);
        chk("mid_rst_out_pc", out_pc, 0);
        chk("mid_rst_out_inst", out_inst, 0);
        @(posedge clk);
        #1;
        reset = 1'b1; redirect_valid = 1'b0; de_ready = 1'b1;
        #1;
        chk("post_rst_addr", imem_addr, 32'h100);
        chk("post_rst_req", 32'(imem_req), 1);
        repeat (20) step(0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
